// File: rtl/nr_alu_mul_seq.sv
// nr_alu_mul_seq -- sequential 8x8 unsigned shift-add multiplier that drives
// one shared combinational nR_ALU, one ALU operation per cycle.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             request a multiply (sampled only in IDLE)
//   op_a, op_b        multiplicand / multiplier, unsigned 8 bit
//   busy              high in every state except IDLE
//   done              one-cycle pulse when result/ovf are valid
//   result            low 8 bits of op_a*op_b, held until next accepted start
//   ovf               product did not fit in 8 bits (sticky per operation)
//   alu_in0, alu_in1  operands driven to the nR_ALU
//   alu_op            nR_ALU opcode (0000 add, 0111 shl, 1000 shr, 0011 idle)
//   alu_out, alu_ovf  nR_ALU result and overflow flags
//
// Configuration
//   NR_MUL_EARLY_EXIT_EN  when defined, the loop stops as soon as the
//                         remaining multiplier is zero, and op_b==0 goes
//                         straight to DONE. Default: always 8 iterations.

module nr_alu_mul_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       ovf,
    output logic [7:0] alu_in0,
    output logic [7:0] alu_in1,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_out,
    input  logic [1:0] alu_ovf
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_IDLE = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHL,
        ST_SHR,
        ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] mcand_q, mcand_d;
    logic [7:0] mplier_q, mplier_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] result_q, result_d;
    logic       ovf_q, ovf_d;
    logic       last_iter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    // Loop exit is evaluated in SHR, where alu_out is the shifted multiplier.
`ifdef NR_MUL_EARLY_EXIT_EN
    assign last_iter = (cnt_q == 3'd7) || (alu_out == 8'd0);
`else
    assign last_iter = (cnt_q == 3'd7);
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        alu_in0  = 8'd0;
        alu_in1  = 8'd0;
        alu_op   = OP_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d    = 8'd0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    cnt_d    = 3'd0;
                    ovf_d    = 1'b0;
`ifdef NR_MUL_EARLY_EXIT_EN
                    if (op_b == 8'd0) begin
                        state_d  = ST_DONE;
                        result_d = 8'd0;
                    end else begin
                        state_d = op_b[0] ? ST_ADD : ST_SHL;
                    end
`else
                    state_d = op_b[0] ? ST_ADD : ST_SHL;
`endif
                end
            end
            ST_ADD: begin
                alu_in0 = acc_q;
                alu_in1 = mcand_q;
                alu_op  = OP_ADD;
                acc_d   = alu_out;
                if (alu_ovf != 2'b00) ovf_d = 1'b1;
                state_d = ST_SHL;
            end
            ST_SHL: begin
                alu_in0 = mcand_q;
                alu_in1 = 8'd1;
                alu_op  = OP_SHL;
                mcand_d = alu_out;
                // The bit shifted out of mcand would still be multiplied by a
                // pending multiplier bit, so the product cannot fit in 8 bits.
                if (mcand_q[7] && (mplier_q[7:1] != 7'd0)) ovf_d = 1'b1;
                state_d = ST_SHR;
            end
            ST_SHR: begin
                alu_in0  = mplier_q;
                alu_in1  = 8'd1;
                alu_op   = OP_SHR;
                mplier_d = alu_out;
                cnt_d    = cnt_q + 3'd1;
                if (last_iter) begin
                    state_d  = ST_DONE;
                    result_d = acc_q;
                end else begin
                    state_d = alu_out[0] ? ST_ADD : ST_SHL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule
